// File: rtl/field_arith_defs.sv
// Field parameters shared by the arithmetic library: Mersenne prime p = 2^61 - 1.
package field_arith_defs;
  localparam int F_NBITS = 61;
  localparam logic [F_NBITS-1:0] F_PRIME = 61'h1FFF_FFFF_FFFF_FFFF;
endpackage

// File: rtl/pergate_amfj_pkg.sv
// Shared types and index-width helpers for pergate_compute_am_fj_n.
package pergate_amfj_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_AM, ST_AMRDY, ST_FJ} state_t;

  function automatic int term_idx_w(input int nfj);
    return (nfj > 1) ? $clog2(nfj) : 1;
  endfunction

  function automatic int bit_idx_w(input int id_bits);
    return (id_bits > 1) ? $clog2(id_bits) : 1;
  endfunction
endpackage

// File: rtl/field_adder.sv
// Combinational modular adder mod 2^61-1.
module field_adder
  import field_arith_defs::*;
(
  input  logic [F_NBITS-1:0] a,
  input  logic [F_NBITS-1:0] b,
  output logic [F_NBITS-1:0] c
);
  logic [F_NBITS:0] s;

  always_comb begin
    s = {1'b0, a} + {1'b0, b};
    c = (s >= {1'b0, F_PRIME}) ? s[F_NBITS-1:0] - F_PRIME : s[F_NBITS-1:0];
  end
endmodule

// File: rtl/field_multiplier.sv
// Modular multiplier mod 2^61-1, one-cycle latency: result and ready one cycle after en.
module field_multiplier
  import field_arith_defs::*;
(
  input  logic               clk,
  input  logic               rstb,
  input  logic               en,
  input  logic [F_NBITS-1:0] a,
  input  logic [F_NBITS-1:0] b,
  output logic [F_NBITS-1:0] c,
  output logic               ready
);
  logic [2*F_NBITS-1:0] a_x, b_x, prod;
  logic [F_NBITS:0]     s1, s2;
  logic [F_NBITS-1:0]   red;

  // Mersenne fold: hi*2^61 + lo == hi + lo (mod p), applied twice then one conditional subtract.
  always_comb begin
    a_x  = {{F_NBITS{1'b0}}, a};
    b_x  = {{F_NBITS{1'b0}}, b};
    prod = a_x * b_x;
    s1   = {1'b0, prod[F_NBITS-1:0]} + {1'b0, prod[2*F_NBITS-1:F_NBITS]};
    s2   = {1'b0, s1[F_NBITS-1:0]} + {{F_NBITS{1'b0}}, s1[F_NBITS]};
    red  = (s2 >= {1'b0, F_PRIME}) ? s2[F_NBITS-1:0] - F_PRIME : s2[F_NBITS-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      ready <= 1'b0;
      c     <= '0;
    end else begin
      ready <= en;
      if (en) c <= red;
    end
  end
endmodule

// File: rtl/pergate_compute_am_fj_n.sv
// Per-gate addmul / fj evaluator sharing one field_multiplier.
// Define PERGATE_AMFJ_ACC_EN to add the fj_sum running-sum output.
module pergate_compute_am_fj_n
  import field_arith_defs::*;
  import pergate_amfj_pkg::*;
#(
  parameter  int NFJ     = 3,
  parameter  int ID_BITS = 4,
  localparam int IDC_W   = $clog2(ID_BITS + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en_am,
  input  logic                           restart,
  input  logic [ID_BITS-1:0]             gate_id,
  input  logic [IDC_W-1:0]               id_count,
  input  logic [F_NBITS-1:0]             tau,
  input  logic [F_NBITS-1:0]             m_tau_p1,
  output logic                           ready_pulse_am,
  output logic                           ready_am,
  output logic [F_NBITS-1:0]             addmul_eval,
  input  logic                           en_fj,
  input  logic [NFJ-1:0][F_NBITS-1:0]    gatefn,
  input  logic [NFJ-1:0][F_NBITS-1:0]    addmul,
  output logic                           ready_fj,
  output logic [NFJ-1:0][F_NBITS-1:0]    fj
`ifdef PERGATE_AMFJ_ACC_EN
  ,
  output logic [F_NBITS-1:0]             fj_sum
`endif
);
  localparam int K_W = bit_idx_w(ID_BITS);
  localparam int J_W = term_idx_w(NFJ);

  state_t                       state, state_nx;
  logic                         en_mul, en_mul_nx;
  logic [F_NBITS-1:0]           am_q;
  logic [ID_BITS-1:0]           gid_q;
  logic [IDC_W-1:0]             idc_q, idc_in;
  logic [K_W-1:0]               k_q;
  logic [J_W-1:0]               j_q;
  logic [NFJ-1:0][F_NBITS-1:0]  fj_q;
  logic [F_NBITS-1:0]           mul_a, mul_b, mul_c;
  logic                         mul_ready;
  logic                         am_start, am_cap, fj_start, fj_cap;
  logic                         k_last, j_last;

  assign idc_in = (id_count > IDC_W'(ID_BITS)) ? IDC_W'(ID_BITS) : id_count;
  assign k_last = (int'(k_q) == int'(idc_q) - 1);
  assign j_last = (int'(j_q) == NFJ - 1);

  field_multiplier u_mul (
    .clk   (clk),
    .rstb  (~rst),
    .en    (en_mul),
    .a     (mul_a),
    .b     (mul_b),
    .c     (mul_c),
    .ready (mul_ready)
  );

  always_comb begin
    state_nx  = state;
    en_mul_nx = 1'b0;
    am_start  = 1'b0;
    am_cap    = 1'b0;
    fj_start  = 1'b0;
    fj_cap    = 1'b0;
    mul_a     = am_q;
    mul_b     = gid_q[k_q] ? tau : m_tau_p1;
    case (state)
      ST_IDLE: begin
        if (en_am) begin
          am_start = 1'b1;
          if (idc_in == '0) begin
            state_nx = ST_AMRDY;
          end else begin
            state_nx  = ST_AM;
            en_mul_nx = 1'b1;
          end
        end else if (en_fj) begin
          fj_start  = 1'b1;
          state_nx  = ST_FJ;
          en_mul_nx = 1'b1;
        end
      end
      ST_AM: begin
        if (mul_ready) begin
          am_cap = 1'b1;
          if (k_last) state_nx = ST_AMRDY;
          else        en_mul_nx = 1'b1;
        end
      end
      ST_AMRDY: state_nx = ST_IDLE;
      ST_FJ: begin
        mul_a = gatefn[j_q];
        mul_b = addmul[j_q];
        if (mul_ready) begin
          fj_cap = 1'b1;
          if (j_last) state_nx = ST_IDLE;
          else        en_mul_nx = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      en_mul <= 1'b0;
      am_q   <= '0;
      gid_q  <= '0;
      idc_q  <= '0;
      k_q    <= '0;
      j_q    <= '0;
      fj_q   <= '0;
    end else begin
      state  <= state_nx;
      en_mul <= en_mul_nx;
      if (am_start) begin
        gid_q <= gate_id;
        idc_q <= idc_in;
        k_q   <= '0;
        if (restart) am_q <= F_NBITS'(1);
      end
      if (am_cap) begin
        am_q <= mul_c;
        k_q  <= k_q + K_W'(1);
      end
      if (fj_start) j_q <= '0;
      if (fj_cap) begin
        fj_q[j_q] <= mul_c;
        j_q       <= j_q + J_W'(1);
      end
    end
  end

  assign ready_am       = ~(((state == ST_IDLE) & en_am) | (state == ST_AM));
  assign ready_fj       = ~(((state == ST_IDLE) & en_fj & ~en_am) | (state == ST_FJ));
  assign ready_pulse_am = (state == ST_AMRDY);
  assign addmul_eval    = am_q;
  assign fj             = fj_q;

`ifdef PERGATE_AMFJ_ACC_EN
  logic [F_NBITS-1:0] sum_q, sum_nx;

  field_adder u_add (
    .a (sum_q),
    .b (mul_c),
    .c (sum_nx)
  );

  always_ff @(posedge clk) begin
    if (rst)         sum_q <= '0;
    else if (fj_start) sum_q <= '0;
    else if (fj_cap)   sum_q <= sum_nx;
  end

  assign fj_sum = sum_q;
`endif
endmodule

// File: tb/tb_pergate_compute_am_fj_n.sv
// Directed bench for pergate_compute_am_fj_n: addmul chains, fj runs, priority, reset abort, field wrap.
module tb_pergate_compute_am_fj_n;
  import field_arith_defs::*;
  import pergate_amfj_pkg::*;

  localparam int NFJ = 3;
  localparam int IDB = 4;
  localparam int P   = 2;
  localparam logic [63:0] PM1 = 64'h1FFF_FFFF_FFFF_FFFE;

  logic                        clk = 1'b0;
  logic                        rst, en_am, restart, en_fj;
  logic [IDB-1:0]              gate_id;
  logic [2:0]                  id_count;
  logic [F_NBITS-1:0]          tau, m_tau_p1;
  logic                        ready_pulse_am, ready_am, ready_fj;
  logic [F_NBITS-1:0]          addmul_eval;
  logic [NFJ-1:0][F_NBITS-1:0] gatefn, addmul, fj;
`ifdef PERGATE_AMFJ_ACC_EN
  logic [F_NBITS-1:0]          fj_sum;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pergate_compute_am_fj_n #(.NFJ(NFJ), .ID_BITS(IDB)) dut (
    .clk            (clk),
    .rst            (rst),
    .en_am          (en_am),
    .restart        (restart),
    .gate_id        (gate_id),
    .id_count       (id_count),
    .tau            (tau),
    .m_tau_p1       (m_tau_p1),
    .ready_pulse_am (ready_pulse_am),
    .ready_am       (ready_am),
    .addmul_eval    (addmul_eval),
    .en_fj          (en_fj),
    .gatefn         (gatefn),
    .addmul         (addmul),
    .ready_fj       (ready_fj),
    .fj             (fj)
`ifdef PERGATE_AMFJ_ACC_EN
    ,
    .fj_sum         (fj_sum)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, act, exp);
    end
  endtask

  // Entered and left at posedge+1. exp_end = edges from the en_am edge to the end of the pulse cycle.
  task automatic run_am(input string tag, input logic rs, input logic [3:0] gid, input logic [2:0] idc,
                        input logic fj_too, input logic poke_fj, input logic [63:0] exp_val,
                        input int exp_end);
    int edges, first, pulses, fjlow;
    first = -1; pulses = 0; fjlow = 0;
    restart = rs; gate_id = gid; id_count = idc; en_am = 1'b1; en_fj = fj_too;
    #1;
    chk({tag, "_ready_am_low"}, 64'(ready_am), 64'd0);
    if (fj_too) chk({tag, "_ready_fj_hold"}, 64'(ready_fj), 64'd1);
    @(posedge clk); #1;
    en_am = 1'b0; en_fj = 1'b0; restart = 1'b0;
    edges = 0;
    while (edges < 30) begin
      en_fj = poke_fj && (edges >= 1) && (edges <= 3);
      #1;
      if (ready_pulse_am) begin
        pulses++;
        if (first < 0) first = edges;
      end
      if (!ready_fj) fjlow++;
      @(posedge clk); #1;
      edges++;
    end
    en_fj = 1'b0;
    chk({tag, "_pulses"}, 64'(pulses), 64'd1);
    chk({tag, "_pulse_end"}, 64'(first + 1), 64'(exp_end));
    chk({tag, "_eval"}, 64'(addmul_eval), exp_val);
    chk({tag, "_ready_am_end"}, 64'(ready_am), 64'd1);
    if (fj_too || poke_fj) chk({tag, "_ready_fj_never_low"}, 64'(fjlow), 64'd0);
  endtask

  task automatic run_fj(input string tag, input logic [63:0] g0, g1, g2, a0, a1, a2,
                        input logic [63:0] e0, e1, e2, esum);
    int edges;
    gatefn[0] = g0[F_NBITS-1:0]; gatefn[1] = g1[F_NBITS-1:0]; gatefn[2] = g2[F_NBITS-1:0];
    addmul[0] = a0[F_NBITS-1:0]; addmul[1] = a1[F_NBITS-1:0]; addmul[2] = a2[F_NBITS-1:0];
    en_fj = 1'b1;
    #1;
    chk({tag, "_ready_fj_low"}, 64'(ready_fj), 64'd0);
    @(posedge clk); #1;
    en_fj = 1'b0;
    edges = 0;
    while (!ready_fj && edges < 50) begin
      @(posedge clk); #1;
      edges++;
    end
    chk({tag, "_latency"}, 64'(edges), 64'(NFJ * P));
    chk({tag, "_fj0"}, 64'(fj[0]), e0);
    chk({tag, "_fj1"}, 64'(fj[1]), e1);
    chk({tag, "_fj2"}, 64'(fj[2]), e2);
`ifdef PERGATE_AMFJ_ACC_EN
    chk({tag, "_sum"}, 64'(fj_sum), esum);
`else
    if (esum == 64'hFFFF_FFFF_FFFF_FFFF) $display("note: esum sentinel");
`endif
  endtask

  initial begin
    rst = 1'b1; en_am = 1'b0; restart = 1'b0; en_fj = 1'b0;
    gate_id = '0; id_count = '0; tau = 61'd3; m_tau_p1 = 61'd7;
    gatefn = '0; addmul = '0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    #1;
    chk("rst_ready_am", 64'(ready_am), 64'd1);
    chk("rst_ready_fj", 64'(ready_fj), 64'd1);
    chk("rst_pulse", 64'(ready_pulse_am), 64'd0);
    chk("rst_eval", 64'(addmul_eval), 64'd0);
    chk("rst_fj", 64'(fj), 64'd0);
`ifdef PERGATE_AMFJ_ACC_EN
    chk("rst_sum", 64'(fj_sum), 64'd0);
`endif
    @(posedge clk); #1;

    // 1*3*7*3, then *7, then restart with zero bits
    run_am("am3", 1'b1, 4'b0101, 3'd3, 1'b0, 1'b0, 64'd63, 3 * P + 1);
    run_am("am1", 1'b0, 4'b0000, 3'd1, 1'b0, 1'b0, 64'd441, 1 * P + 1);
    run_am("am0", 1'b1, 4'b0000, 3'd0, 1'b0, 1'b0, 64'd1, 1);

    run_fj("fj", 2, 3, 4, 5, 6, 7, 10, 18, 28, 56);

    // en_am wins over en_fj; en_fj pokes during ST_AM are ignored; 1*7*7
    run_am("prio", 1'b1, 4'b0000, 3'd2, 1'b1, 1'b1, 64'd49, 2 * P + 1);
    chk("prio_fj0", 64'(fj[0]), 64'd10);
    chk("prio_fj1", 64'(fj[1]), 64'd18);
    chk("prio_fj2", 64'(fj[2]), 64'd28);
`ifdef PERGATE_AMFJ_ACC_EN
    chk("prio_sum", 64'(fj_sum), 64'd56);
`endif

    // id_count 7 clamps to 4 bits: 3^4
    run_am("clamp", 1'b1, 4'b1111, 3'd7, 1'b0, 1'b0, 64'd81, 4 * P + 1);

    tau = PM1[F_NBITS-1:0]; m_tau_p1 = PM1[F_NBITS-1:0];
    run_am("wrap", 1'b1, 4'b0110, 3'd2, 1'b0, 1'b0, 64'd1, 2 * P + 1);
    tau = 61'd3; m_tau_p1 = 61'd7;

    // Reset during the second fj product
    gatefn[0] = 61'd3; gatefn[1] = 61'd3; gatefn[2] = 61'd3;
    addmul[0] = 61'd3; addmul[1] = 61'd3; addmul[2] = 61'd3;
    en_fj = 1'b1;
    @(posedge clk); #1;
    en_fj = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_partial_fj0", 64'(fj[0]), 64'd9);
    chk("abort_keep_fj1", 64'(fj[1]), 64'd18);
    chk("abort_keep_fj2", 64'(fj[2]), 64'd28);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_state", 64'(dut.state), 64'(ST_IDLE));
    chk("abort_fj", 64'(fj), 64'd0);
    chk("abort_eval", 64'(addmul_eval), 64'd0);
    chk("abort_ready_am", 64'(ready_am), 64'd1);
    chk("abort_ready_fj", 64'(ready_fj), 64'd1);
`ifdef PERGATE_AMFJ_ACC_EN
    chk("abort_sum", 64'(fj_sum), 64'd0);
`endif
    @(posedge clk); #1;

    run_fj("fj_fresh", 2, 3, 4, 5, 6, 7, 10, 18, 28, 56);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
